// File: rtl/sharpen_kernel_3x3_pkg.sv
// Shared constants and clamp helper for the 3x3 sharpening path.
// Build option: SHARPEN_DIAG_EN selects the 8-neighbour kernel.
package sharpen_pkg;

  localparam int PIX_W = 8;

`ifdef SHARPEN_DIAG_EN
  localparam int SUM_XTRA    = 5;
  localparam int CENTRE_COEF = 9;
  localparam int TB_DEPTH    = 3;
`else
  localparam int SUM_XTRA    = 4;
  localparam int CENTRE_COEF = 5;
  // Corners unused: top/bottom rows only need centre and right columns
  localparam int TB_DEPTH    = 2;
`endif

  localparam int SUM_W   = PIX_W + SUM_XTRA;
  localparam int PIX_MAX = (1 << PIX_W) - 1;

  function automatic logic [31:0] sat_pix(
    input logic signed [31:0] s,
    input int                 w
  );
    logic [31:0] mx;
    mx = (32'd1 << w) - 32'd1;
    if (s < 0) return '0;
    if (s > $signed(mx)) return mx;
    return $unsigned(s);
  endfunction

endpackage

// File: rtl/sharpen_kernel_3x3_if.sv
// Column-in / pixel-out bus of the 3x3 sharpening kernel.
// No backpressure: the sink always accepts data_out.
interface sharpen_kernel_3x3_if
  import sharpen_pkg::*;
#(
  parameter int WIDTH = PIX_W
);

  logic [WIDTH-1:0] row_top;
  logic [WIDTH-1:0] row_mid;
  logic [WIDTH-1:0] row_bot;
  logic             data_in_valid;
  logic [WIDTH-1:0] data_out;
  logic             data_out_valid;
  logic             line_done;

  modport master (
    output row_top,
    output row_mid,
    output row_bot,
    output data_in_valid,
    input  data_out,
    input  data_out_valid,
    input  line_done
  );

  modport slave (
    input  row_top,
    input  row_mid,
    input  row_bot,
    input  data_in_valid,
    output data_out,
    output data_out_valid,
    output line_done
  );

endinterface

// File: rtl/sharpen_kernel_3x3_window_3x3.sv
// 3x3 window shift registers with column counter and row-wrap gating.
// SHARPEN_DIAG_EN adds the corner taps and their storage.
module window_3x3
  import sharpen_pkg::*;
#(
  parameter int WIDTH     = PIX_W,
  parameter int IMG_WIDTH = 512,
  parameter int COL_BITS  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_top,
  input  logic [WIDTH-1:0] i_mid,
  input  logic [WIDTH-1:0] i_bot,
`ifdef SHARPEN_DIAG_EN
  output logic [WIDTH-1:0] o_nw,
  output logic [WIDTH-1:0] o_ne,
  output logic [WIDTH-1:0] o_sw,
  output logic [WIDTH-1:0] o_se,
`endif
  output logic [WIDTH-1:0] o_n,
  output logic [WIDTH-1:0] o_w,
  output logic [WIDTH-1:0] o_c,
  output logic [WIDTH-1:0] o_e,
  output logic [WIDTH-1:0] o_s,
  output logic             o_win_valid,
  output logic             o_win_last
);

  localparam logic [COL_BITS-1:0] COL_END =
    COL_BITS'(IMG_WIDTH - 1);

  logic [WIDTH-1:0]    r_top [TB_DEPTH];
  logic [WIDTH-1:0]    r_mid [3];
  logic [WIDTH-1:0]    r_bot [TB_DEPTH];
  logic [COL_BITS-1:0] r_col;
  logic                r_full;
  logic                r_win_valid;
  logic                r_win_last;
  logic                w_col_end;
  logic                w_win_ok;

  assign w_col_end = (r_col == COL_END);
  assign w_win_ok  = r_full && (r_col >= COL_BITS'(2));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_top       <= '{default: '0};
      r_mid       <= '{default: '0};
      r_bot       <= '{default: '0};
      r_col       <= '0;
      r_full      <= 1'b0;
      r_win_valid <= 1'b0;
      r_win_last  <= 1'b0;
    end else begin
      r_win_valid <= i_valid && w_win_ok;
      r_win_last  <= i_valid && w_win_ok && w_col_end;
      if (i_valid) begin
        for (int i = 0; i < TB_DEPTH - 1; i++) begin
          r_top[i] <= r_top[i+1];
          r_bot[i] <= r_bot[i+1];
        end
        r_top[TB_DEPTH-1] <= i_top;
        r_bot[TB_DEPTH-1] <= i_bot;
        r_mid[0] <= r_mid[1];
        r_mid[1] <= r_mid[2];
        r_mid[2] <= i_mid;
        r_col  <= w_col_end ? '0 : r_col + 1'b1;
        // Cleared on wrap so no previous-row column can form a window
        r_full <= (r_col != '0) && !w_col_end;
      end
    end
  end

`ifdef SHARPEN_DIAG_EN
  assign o_nw = r_top[0];
  assign o_ne = r_top[2];
  assign o_sw = r_bot[0];
  assign o_se = r_bot[2];
`endif
  assign o_n         = r_top[TB_DEPTH-2];
  assign o_s         = r_bot[TB_DEPTH-2];
  assign o_w         = r_mid[0];
  assign o_c         = r_mid[1];
  assign o_e         = r_mid[2];
  assign o_win_valid = r_win_valid;
  assign o_win_last  = r_win_last;

endmodule

// File: rtl/sharpen_kernel_3x3.sv
// 3x3 sharpening kernel: window, signed sum stage, clamp stage.
// SHARPEN_DIAG_EN selects the 8-neighbour kernel (centre 9).
module sharpen_kernel_3x3
  import sharpen_pkg::*;
#(
  parameter int WIDTH     = PIX_W,
  parameter int IMG_WIDTH = 512,
  parameter int COL_BITS  = 10
) (
  input logic                 clk,
  input logic                 reset,
  sharpen_kernel_3x3_if.slave bus
);

  localparam int SW = WIDTH + SUM_XTRA;

  logic [WIDTH-1:0]     w_n, w_s, w_w, w_c, w_e;
`ifdef SHARPEN_DIAG_EN
  logic [WIDTH-1:0]     w_nw, w_ne, w_sw, w_se;
`endif
  logic                 w_win_valid;
  logic                 w_win_last;
  logic signed [SW-1:0] w_sum;

  logic signed [SW-1:0] r_sum;
  logic                 r_s1_valid;
  logic                 r_s1_last;
  logic [WIDTH-1:0]     r_out;
  logic                 r_out_valid;
  logic                 r_line_done;

  window_3x3 #(
    .WIDTH     (WIDTH),
    .IMG_WIDTH (IMG_WIDTH),
    .COL_BITS  (COL_BITS)
  ) u_win (
    .clk         (clk),
    .reset       (reset),
    .i_valid     (bus.data_in_valid),
    .i_top       (bus.row_top),
    .i_mid       (bus.row_mid),
    .i_bot       (bus.row_bot),
`ifdef SHARPEN_DIAG_EN
    .o_nw        (w_nw),
    .o_ne        (w_ne),
    .o_sw        (w_sw),
    .o_se        (w_se),
`endif
    .o_n         (w_n),
    .o_w         (w_w),
    .o_c         (w_c),
    .o_e         (w_e),
    .o_s         (w_s),
    .o_win_valid (w_win_valid),
    .o_win_last  (w_win_last)
  );

  function automatic logic signed [SW-1:0] ext(
    input logic [WIDTH-1:0] p
  );
    return $signed({{SUM_XTRA{1'b0}}, p});
  endfunction

  always_comb begin
    w_sum = SW'(CENTRE_COEF) * ext(w_c);
    w_sum = w_sum - ext(w_n) - ext(w_s);
    w_sum = w_sum - ext(w_w) - ext(w_e);
`ifdef SHARPEN_DIAG_EN
    w_sum = w_sum - ext(w_nw) - ext(w_ne);
    w_sum = w_sum - ext(w_sw) - ext(w_se);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sum       <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_line_done <= 1'b0;
    end else begin
      r_s1_valid  <= w_win_valid;
      r_s1_last   <= w_win_last;
      r_out_valid <= r_s1_valid;
      r_line_done <= r_s1_valid && r_s1_last;
      if (w_win_valid) begin
        r_sum <= w_sum;
      end
      if (r_s1_valid) begin
        r_out <= WIDTH'(sat_pix(32'(r_sum), WIDTH));
      end
    end
  end

  assign bus.data_out       = r_out;
  assign bus.data_out_valid = r_out_valid;
  assign bus.line_done      = r_line_done;

endmodule

// File: tb/tb_sharpen_kernel_3x3.sv
// Scoreboard bench for sharpen_kernel_3x3 at IMG_WIDTH=8.
// Expected pixels are hand-computed per row and queued before driving.
`timescale 1ns/1ps
module tb_sharpen_kernel_3x3;

  localparam int W  = 8;
  localparam int IW = 8;
  localparam int CB = 4;

  typedef struct {
    logic [7:0] pix;
    logic       last;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  sharpen_kernel_3x3_if #(.WIDTH(W)) bus();

  sharpen_kernel_3x3 #(
    .WIDTH     (W),
    .IMG_WIDTH (IW),
    .COL_BITS  (CB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t       q[$];
  exp_t       m_e;
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] ct [IW];
  logic [7:0] cm [IW];
  logic [7:0] cb [IW];
  logic [7:0] ex [IW-2];

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < IW; i++) begin
      ct[i] = v;
      cm[i] = v;
      cb[i] = v;
    end
  endtask

  task automatic push_row();
    for (int i = 0; i < IW - 2; i++)
      q.push_back('{ex[i], (i == IW - 3)});
  endtask

  task automatic send_row(input int nb, input bit gaps, input bit lat);
    for (int j = 0; j < nb; j++) begin
      @(negedge clk);
      if (lat && (j == 3 || j == 4))
        chk("lat_early", 32'(bus.data_out_valid), 32'd0);
      if (lat && j == 5)
        chk("lat_first", 32'(bus.data_out_valid), 32'd1);
      bus.row_top       = ct[j];
      bus.row_mid       = cm[j];
      bus.row_bot       = cb[j];
      bus.data_in_valid = 1'b1;
      if (gaps) begin
        @(negedge clk);
        bus.data_in_valid = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.data_in_valid = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (bus.data_out_valid) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL extra_out: got pix %0d, want no output",
                 bus.data_out);
      end else begin
        m_e = q.pop_front();
        if (bus.data_out !== m_e.pix || bus.line_done !== m_e.last) begin
          n_err++;
          $display("FAIL pixel: got %0d/ld=%0b, want %0d/ld=%0b",
                   bus.data_out, bus.line_done, m_e.pix, m_e.last);
        end
      end
    end else if (bus.line_done) begin
      n_vec++;
      n_err++;
      $display("FAIL stray_line_done: got 1, want 0");
    end
  end

  initial begin
    bus.row_top       = '0;
    bus.row_mid       = '0;
    bus.row_bot       = '0;
    bus.data_in_valid = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_data",  32'(bus.data_out), 32'd0);
    chk("rst_valid", 32'(bus.data_out_valid), 32'd0);
    chk("rst_done",  32'(bus.line_done), 32'd0);
    reset = 1'b1;

    // flat field
    fill(8'd100);
    ex = '{100, 100, 100, 100, 100, 100};
    push_row();
    send_row(IW, 1'b0, 1'b1);
    idle(4);

    // bright centre column clamps high, neighbours clamp to 0
    fill(8'd100);
    cm[3] = 8'd200;
    ex = '{100, 0, 255, 0, 100, 100};
    push_row();
    send_row(IW, 1'b0, 1'b0);
    idle(4);

    // dark centre surrounded by 255 clamps low
    fill(8'd255);
    cm[3] = 8'd0;
    ex = '{255, 255, 0, 255, 255, 255};
    push_row();
    send_row(IW, 1'b0, 1'b0);
    idle(4);

    // valid toggling every cycle
    fill(8'd100);
    ex = '{100, 100, 100, 100, 100, 100};
    push_row();
    send_row(IW, 1'b1, 1'b0);
    idle(4);

    // back-to-back rows
    fill(8'd0);
    ex = '{0, 0, 0, 0, 0, 0};
    push_row();
    send_row(IW, 1'b0, 1'b0);
    fill(8'd200);
    ex = '{200, 200, 200, 200, 200, 200};
    push_row();
    send_row(IW, 1'b0, 1'b0);
    idle(4);

    // reset mid-row after beat 4
    fill(8'd100);
    send_row(4, 1'b0, 1'b0);
    @(negedge clk);
    bus.data_in_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("mid_rst_data",  32'(bus.data_out), 32'd0);
    chk("mid_rst_valid", 32'(bus.data_out_valid), 32'd0);
    chk("mid_rst_done",  32'(bus.line_done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    fill(8'd50);
    ex = '{50, 50, 50, 50, 50, 50};
    push_row();
    send_row(IW, 1'b0, 1'b1);
    idle(4);

    for (int k = 0; k < 20 && q.size() != 0; k++)
      @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
